// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC: FSM encodings, pi, 1/K and the atan(2^-i) table.
// Fixed-point constants are kept at high precision and rounded down to the word format on use.
package cordic_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t COMP = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam int PI_Q18      = 823550;
    localparam int HALF_PI_Q18 = 411775;

    localparam longint PI_Q30    = 64'sd3373259426;
    localparam longint INV_K_Q32 = 64'sd2608131496;

    // Rounds half-up when dropping s fraction bits; a non-positive s widens instead.
    function automatic longint round_shift(input longint v, input int s);
        if (s <= 0)
            return v <<< (-s);
        return (v + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

    function automatic longint atan_q30(input int i);
        case (i)
            0:       return 64'sd843314857;
            1:       return 64'sd497837830;
            2:       return 64'sd263043837;
            3:       return 64'sd133525159;
            4:       return 64'sd67021687;
            5:       return 64'sd33543516;
            6:       return 64'sd16775851;
            7:       return 64'sd8388437;
            8:       return 64'sd4194283;
            9:       return 64'sd2097149;
            default: return (i <= 30) ? (64'sd1 <<< (30 - i)) : 64'sd0;
        endcase
    endfunction

    function automatic longint atan_q(input int i, input int frac);
        return round_shift(atan_q30(i), 30 - frac);
    endfunction

    function automatic longint pi_q(input int frac);
        return round_shift(PI_Q30, 30 - frac);
    endfunction

    function automatic longint half_pi_q(input int frac);
        return round_shift(PI_Q30, 31 - frac);
    endfunction

    function automatic longint inv_k_q(input int width);
        return round_shift(INV_K_Q32, 32 - width);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: index i -> atan(2^-i) in the widened Q2.(WORD_LENGTH-3) datapath format.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH = 21,
    parameter int IDX_W       = $clog2(WORD_LENGTH + 1)
) (
    input  logic [IDX_W-1:0]         index,
    output logic signed [WORD_LENGTH+1:0] atan
);

    localparam int DW = WORD_LENGTH + 2;

    logic signed [DW-1:0] atan_tab [WORD_LENGTH];

    for (genvar g = 0; g < WORD_LENGTH; g++) begin : g_tab
        assign atan_tab[g] = DW'(atan_q(g, WORD_LENGTH - 3));
    end

    always_comb begin
        atan = '0;
        if (index < IDX_W'(WORD_LENGTH))
            atan = atan_tab[index];
    end

endmodule

// File: rtl/cordic_vector_iter.sv
// Folded vectoring-mode CORDIC: (x,y) -> (magnitude, angle), one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a COMP cycle that scales the magnitude by 1/K.
module cordic_vector_iter
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH = 21,
    parameter int N_ITER      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WORD_LENGTH-1:0] x_in,
    input  logic signed [WORD_LENGTH-1:0] y_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WORD_LENGTH-1:0] mag_out,
    output logic signed [WORD_LENGTH-1:0] ang_out
);

    localparam int W    = WORD_LENGTH;
    localparam int DW   = W + 2;
    localparam int FRAC = W - 3;
    localparam int CW   = $clog2(W + 1);

    localparam logic signed [DW-1:0] PI_D    = DW'(pi_q(FRAC));
    localparam logic signed [DW-1:0] ANG_MIN = DW'(64'sd1 - pi_q(FRAC));
    localparam logic signed [DW-1:0] MAX_D   = DW'((64'sd1 <<< (W - 1)) - 64'sd1);

    state_t               state;
    logic [CW-1:0]        count;
    logic signed [DW-1:0] x, y, z;
    logic signed [DW-1:0] x_nx, y_nx, z_nx;
    logic signed [DW-1:0] atan_i;
    logic signed [DW-1:0] x_ext, y_ext;
    logic                 zero_in;

    cordic_atan_rom #(
        .WORD_LENGTH(W),
        .IDX_W      (CW)
    ) u_atan_rom (
        .index(count),
        .atan (atan_i)
    );

    function automatic logic signed [W-1:0] sat_mag(input logic signed [DW-1:0] v);
        if (v < 0)
            return '0;
        if (v > MAX_D)
            return W'(MAX_D);
        return W'(v);
    endfunction

    // Angle is clamped into (-pi, +pi] so residual error never flips the sign near the branch cut.
    function automatic logic signed [W-1:0] sat_ang(input logic signed [DW-1:0] v);
        if (v > PI_D)
            return W'(PI_D);
        if (v < ANG_MIN)
            return W'(ANG_MIN);
        return W'(v);
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign x_ext     = DW'(x_in);
    assign y_ext     = DW'(y_in);

    // One micro-rotation toward y = 0; all three updates read the pre-step values.
    always_comb begin
        x_nx = x;
        y_nx = y;
        z_nx = z;
        if (y[DW-1]) begin
            x_nx = x - (y >>> count);
            y_nx = y + (x >>> count);
            z_nx = z - atan_i;
        end else begin
            x_nx = x + (y >>> count);
            y_nx = y - (x >>> count);
            z_nx = z + atan_i;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = DW + W + 1;
    localparam logic signed [W:0] INV_K_S = (W + 1)'(inv_k_q(W));

    logic signed [PW-1:0] prod;
    logic signed [DW-1:0] mag_comp;

    always_comb begin
        prod     = PW'(x) * PW'(INV_K_S);
        mag_comp = DW'((prod + (PW'(1) <<< (W - 1))) >>> W);
    end
`endif

    // Control and datapath share one register block so an abort clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            zero_in <= 1'b0;
            mag_out <= '0;
            ang_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        count   <= '0;
                        zero_in <= (x_in == '0) && (y_in == '0);
                        if (x_in < 0) begin
                            x <= -x_ext;
                            y <= -y_ext;
                            z <= (y_in < 0) ? -PI_D : PI_D;
                        end else begin
                            x <= x_ext;
                            y <= y_ext;
                            z <= '0;
                        end
                        state <= RUN;
                    end
                end
                RUN: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    if (count == CW'(N_ITER - 1)) begin
                        count <= '0;
`ifdef CORDIC_GAIN_COMP_EN
                        state <= COMP;
`else
                        mag_out <= sat_mag(x_nx);
                        ang_out <= zero_in ? '0 : sat_ang(z_nx);
                        state   <= DONE;
`endif
                    end else begin
                        count <= count + CW'(1);
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: begin
                    mag_out <= sat_mag(mag_comp);
                    ang_out <= zero_in ? '0 : sat_ang(z);
                    state   <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
